// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the two-road lamp buses; dwell checks built only with TRAFFIC_MONITOR_DWELL_CHECK_EN.
// Latency: an offending sample shows on phase/fault/fault_code one edge later.
// Backpressure: none; observes every cycle and never stalls the light controller.
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 6,
    parameter int YELLOW_CYCLES = 3,
    parameter int CNT_W         = 16,
    parameter int RUN_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       roadA,
    input  logic [2:0]       roadB,
    input  logic             fault_clr,
    output logic [2:0]       phase,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [2:0] PH_SYNC  = 3'd0;
    localparam logic [2:0] PH_AG    = 3'd1;
    localparam logic [2:0] PH_AY    = 3'd2;
    localparam logic [2:0] PH_BG    = 3'd3;
    localparam logic [2:0] PH_BY    = 3'd4;
    localparam logic [2:0] PH_FAULT = 3'd7;

    localparam logic [2:0] CODE_ENC      = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_ORDER    = 3'd3;
    localparam logic [2:0] CODE_SHORT    = 3'd4;
    localparam logic [2:0] CODE_LONG     = 3'd5;

    localparam int MAX_DWELL = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;

    if (RUN_W < $clog2(MAX_DWELL + 2)) begin : g_run_w_check
        $error("RUN_W cannot hold the longest dwell plus one");
    end

    // Maps a lamp pair to the phase it represents; PH_SYNC marks an illegal pair.
    function automatic logic [2:0] pat_of(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] p;
        p = PH_SYNC;
        if (a == LAMP_G && b == LAMP_R)      p = PH_AG;
        else if (a == LAMP_Y && b == LAMP_R) p = PH_AY;
        else if (a == LAMP_R && b == LAMP_G) p = PH_BG;
        else if (a == LAMP_R && b == LAMP_Y) p = PH_BY;
        return p;
    endfunction

    function automatic logic lamp_ok(input logic [2:0] x);
        return (x == LAMP_R) || (x == LAMP_Y) || (x == LAMP_G);
    endfunction

    logic [2:0] prev_a;
    logic [2:0] prev_b;
    logic       prev_valid;

    logic [2:0] cur_pat;
    logic [2:0] prev_pat;
    logic [2:0] next_pat;
    logic       changed;
    logic       enc_bad;
    logic       conflict;
    logic       order_bad;
    logic       dwell_short;
    logic       dwell_long;
    logic [2:0] det_code;

    assign cur_pat   = pat_of(roadA, roadB);
    assign prev_pat  = pat_of(prev_a, prev_b);
    assign next_pat  = (prev_pat == PH_BY) ? PH_AG : prev_pat + 3'd1;
    assign changed   = (roadA != prev_a) || (roadB != prev_b);
    assign enc_bad   = !lamp_ok(roadA) || !lamp_ok(roadB);
    assign conflict  = (roadA != LAMP_R) && (roadB != LAMP_R);
    // An illegal first sample in SYNC has no order to violate; only the new pattern is judged.
    assign order_bad = (cur_pat == PH_SYNC) ||
                       (changed && prev_pat != PH_SYNC && cur_pat != next_pat);

`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] req_dwell;
    logic             tracked;

    assign tracked     = (phase >= PH_AG) && (phase <= PH_BY);
    assign req_dwell   = (phase == PH_AG || phase == PH_BG) ? RUN_W'(GREEN_CYCLES)
                                                            : RUN_W'(YELLOW_CYCLES);
    assign dwell_short = tracked && changed && (run_len < req_dwell);
    assign dwell_long  = tracked && !changed && (run_len == req_dwell);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_len <= '0;
        end else if (!fault_clr && phase != PH_FAULT && prev_valid && det_code == 3'd0) begin
            if (changed)
                run_len <= RUN_W'(1);
            else if (tracked)
                run_len <= run_len + RUN_W'(1);
        end
    end
`else
    assign dwell_short = 1'b0;
    assign dwell_long  = 1'b0;
`endif

    always_comb begin
        det_code = 3'd0;
        if (enc_bad)          det_code = CODE_ENC;
        else if (conflict)    det_code = CODE_CONFLICT;
        else if (order_bad)   det_code = CODE_ORDER;
        else if (dwell_short) det_code = CODE_SHORT;
        else if (dwell_long)  det_code = CODE_LONG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= PH_SYNC;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            cycle_count <= '0;
            prev_a      <= 3'd0;
            prev_b      <= 3'd0;
            prev_valid  <= 1'b0;
        end else if (fault_clr) begin
            phase      <= PH_SYNC;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            prev_valid <= 1'b0;
        end else if (phase != PH_FAULT) begin
            if (!prev_valid) begin
                prev_a     <= roadA;
                prev_b     <= roadB;
                prev_valid <= 1'b1;
            end else if (det_code != 3'd0) begin
                phase      <= PH_FAULT;
                fault      <= 1'b1;
                fault_code <= det_code;
            end else begin
                prev_a <= roadA;
                prev_b <= roadB;
                // With no fault, a change always lands on a legal pattern.
                if (changed) begin
                    phase <= cur_pat;
                    if (phase == PH_BY && cycle_count != {CNT_W{1'b1}})
                        cycle_count <= cycle_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a phase-level model is compared every cycle,
// with hand-computed literal checks pinning key points of each scenario.
module tb_traffic_light_monitor;

    localparam int G_CYC = 6;
    localparam int Y_CYC = 3;
    localparam int CW    = 16;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    roadA = R;
    logic [2:0]    roadB = R;
    logic          fault_clr = 1'b0;
    logic [2:0]    phase;
    logic          fault;
    logic [2:0]    fault_code;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int failures = 0;

    traffic_light_monitor #(
        .GREEN_CYCLES (G_CYC),
        .YELLOW_CYCLES(Y_CYC),
        .CNT_W        (CW),
        .RUN_W        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .roadA      (roadA),
        .roadB      (roadB),
        .fault_clr  (fault_clr),
        .phase      (phase),
        .fault      (fault),
        .fault_code (fault_code),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Model state, phase numbers as in the interface: 0 sync, 1..4 tracked, 7 fault.
    int       m_phase = 0;
    int       m_fault = 0;
    int       m_code = 0;
    int       m_count = 0;
    int       m_run = 0;
    bit       m_have_prev = 0;
    bit [2:0] m_pa = 0;
    bit [2:0] m_pb = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Index 1..4 into the legal cyclic sequence, 0 when the pair is not legal.
    function automatic int pat_idx(input bit [2:0] a, input bit [2:0] b);
        bit [2:0] ta[4];
        bit [2:0] tb[4];
        ta = '{G, Y, R, R};
        tb = '{R, R, G, Y};
        for (int i = 0; i < 4; i++)
            if (a == ta[i] && b == tb[i]) return i + 1;
        return 0;
    endfunction

    function automatic bit one_lamp(input bit [2:0] x);
        return (x == R) || (x == Y) || (x == G);
    endfunction

    function automatic int dwell_of(input int ph);
        return (ph == 1 || ph == 3) ? G_CYC : Y_CYC;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_fault = 0; m_code = 0; m_count = 0; m_run = 0;
        m_have_prev = 0; m_pa = 0; m_pb = 0;
    endtask

    task automatic model_step(input bit [2:0] a, input bit [2:0] b, input bit clr);
        int  code;
        int  idx;
        int  pidx;
        bit  chg;
        bit  trk;
        if (clr) begin
            m_phase = 0; m_fault = 0; m_code = 0; m_have_prev = 0;
            return;
        end
        if (m_phase == 7) return;
        if (!m_have_prev) begin
            m_pa = a; m_pb = b; m_have_prev = 1;
            return;
        end
        idx  = pat_idx(a, b);
        pidx = pat_idx(m_pa, m_pb);
        chg  = (a != m_pa) || (b != m_pb);
        trk  = (m_phase >= 1 && m_phase <= 4);
        code = 0;
        if (!one_lamp(a) || !one_lamp(b))                           code = 1;
        else if (a != R && b != R)                                  code = 2;
        else if (idx == 0 || (chg && pidx != 0 && idx != pidx % 4 + 1)) code = 3;
`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
        else if (trk && chg && m_run < dwell_of(m_phase))           code = 4;
        else if (trk && !chg && m_run == dwell_of(m_phase))         code = 5;
`endif
        if (code != 0) begin
            m_phase = 7; m_fault = 1; m_code = code;
            return;
        end
        m_pa = a; m_pb = b;
        if (chg) begin
            if (m_phase == 4 && m_count < (1 << CW) - 1) m_count++;
            m_phase = idx;
            m_run = 1;
        end else if (trk) begin
            m_run++;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("phase", int'(phase), m_phase);
            check("fault", int'(fault), m_fault);
            check("fault_code", int'(fault_code), m_code);
            check("cycle_count", int'(cycle_count), m_count);
        end
    end

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr);
        roadA = a; roadB = b; fault_clr = clr;
        @(posedge clk);
        model_step(a, b, clr);
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
        for (int i = 0; i < n; i++) step(a, b, 1'b0);
    endtask

    task automatic period();
        hold(G, R, G_CYC); hold(Y, R, Y_CYC); hold(R, G, G_CYC); hold(R, Y, Y_CYC);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_phase", int'(phase), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_code", int'(fault_code), 0);
        check("rst_count", int'(cycle_count), 0);
        reset = 1'b0;

        // Ten legal periods, then the first sample of the eleventh completes cycle ten
        hold(G, R, G_CYC);
        hold(Y, R, 1);
        check("first_tracked_phase", int'(phase), 2);
        hold(Y, R, Y_CYC - 1); hold(R, G, G_CYC); hold(R, Y, Y_CYC);
        for (int p = 1; p < 10; p++) period();
        hold(G, R, 1);
        check("ten_cycles", int'(cycle_count), 10);
        check("ten_cycles_phase", int'(phase), 1);
        check("ten_cycles_fault", int'(fault), 0);

        // Bad encoding in tracked A_GREEN, then frozen
        hold(G, R, 2);
        step(3'b011, R, 1'b0);
        check("enc_code", int'(fault_code), 1);
        check("enc_phase", int'(phase), 7);
        hold(G, R, 3);
        check("enc_frozen_code", int'(fault_code), 1);
        check("enc_count_held", int'(cycle_count), 10);

        // Conflict in tracked B_GREEN, then clear
        step(G, R, 1'b1);
        check("clr_phase", int'(phase), 0);
        check("clr_fault", int'(fault), 0);
        hold(G, R, 2); hold(Y, R, Y_CYC); hold(R, G, 2);
        check("bg_phase", int'(phase), 3);
        step(G, G, 1'b0);
        check("conflict_code", int'(fault_code), 2);
        step(R, G, 1'b1);
        check("clr2_phase", int'(phase), 0);
        check("clr2_fault", int'(fault), 0);

        // Skipped phase from tracked A_GREEN, and an illegal pair in SYNC
        hold(R, Y, 2); hold(G, R, G_CYC);
        step(R, G, 1'b0);
        check("order_code", int'(fault_code), 3);
        step(R, R, 1'b1);
        step(R, R, 1'b0);
        check("sync_first_load", int'(fault), 0);
        step(R, R, 1'b0);
        check("rr_code", int'(fault_code), 3);

        // Dwell too short, then dwell too long
        step(R, Y, 1'b1);
        hold(R, Y, 2); hold(G, R, G_CYC - 1);
        step(Y, R, 1'b0);
`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
        check("short_code", int'(fault_code), 4);
`else
        check("short_nodwell_fault", int'(fault), 0);
        check("short_nodwell_phase", int'(phase), 2);
`endif
        step(G, R, 1'b1);
        hold(G, R, 2); hold(Y, R, Y_CYC);
        check("yellow_full_fault", int'(fault), 0);
        step(Y, R, 1'b0);
`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
        check("long_code", int'(fault_code), 5);
`else
        check("long_nodwell_fault", int'(fault), 0);
`endif

        // Async reset mid-B_YELLOW with three completed cycles
        do_reset();
        for (int p = 0; p < 3; p++) period();
        hold(G, R, G_CYC); hold(Y, R, Y_CYC); hold(R, G, G_CYC); hold(R, Y, 2);
        check("pre_reset_count", int'(cycle_count), 3);
        check("pre_reset_phase", int'(phase), 4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_phase", int'(phase), 0);
        check("async_rst_count", int'(cycle_count), 0);
        check("async_rst_fault", int'(fault), 0);
        @(negedge clk);
        reset = 1'b0;

        // Clear wins over a bad encoding on the same edge
        hold(G, R, 2); hold(Y, R, 1);
        step(3'b111, R, 1'b1);
        check("clr_vs_enc_fault", int'(fault), 0);
        check("clr_vs_enc_phase", int'(phase), 0);
        step(3'b000, R, 1'b0);
        check("post_clr_load_fault", int'(fault), 0);
        step(G, R, 1'b0);
        check("post_clr_enter", int'(phase), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker for the two-road light interface: roadA/roadB, 3-bit one-hot lamps (RED=100, YELLOW=010, GREEN=001).
- Decodes the lamp buses into a phase, then checks encoding, mutual exclusion, phase order and dwell times.
- Raises a sticky, coded fault and counts completed signal cycles.
- Sits on the same clock as the light controller, in the safety/supervision path of the intersection.

Parameters:
- GREEN_CYCLES, 6: required consecutive samples of each green phase.
- YELLOW_CYCLES, 3: required consecutive samples of each yellow phase.
- CNT_W, 16: width of cycle_count.
- RUN_W, 8: width of the internal run-length counter; must hold max(GREEN_CYCLES, YELLOW_CYCLES)+1.

Ports:
- clk, in, 1: system clock; all state updates on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- roadA, in, 3: observed lamp code for road A.
- roadB, in, 3: observed lamp code for road B.
- fault_clr, in, 1: synchronous pulse that clears the fault and returns to SYNC.
- phase, out, 3: 0=SYNC, 1=A_GREEN, 2=A_YELLOW, 3=B_GREEN, 4=B_YELLOW, 7=FAULT.
- fault, out, 1: sticky fault flag.
- fault_code, out, 3: 0=none, 1=bad encoding, 2=conflict, 3=illegal pattern/transition, 4=dwell short, 5=dwell long.
- cycle_count, out, CNT_W: completed A_GREEN→…→B_YELLOW→A_GREEN cycles, saturating at all-ones.

Behaviour:
- Reset values: phase=SYNC, fault=0, fault_code=0, cycle_count=0, run_len=0, prev_valid=0.
- Legal patterns (A,B): (G,R)=A_GREEN, (Y,R)=A_YELLOW, (R,G)=B_GREEN, (R,Y)=B_YELLOW. Legal order is cyclic in that sequence.
- Sampling: every edge samples roadA/roadB. Checks compare the current sample with the registered previous pattern. Outputs update at that same edge, so an offending sample before edge N gives fault=1 after edge N (latency 1).
- Check priority, highest first; only the highest failing check is recorded:
  1) Either bus is not RED, YELLOW or GREEN → code 1.
  2) Both buses are non-RED → code 2.
  3) Pattern is not legal (e.g. R,R), or a pattern change is not the next in the cyclic order → code 3.
  4) Pattern changes while run_len < required dwell of the old phase → code 4.
  5) Same pattern sampled while run_len == required dwell (run would exceed it) → code 5.
- run_len: set to 1 on the first sample of a new pattern; incremented on each repeat sample.
- SYNC: checks 1–3 apply, except that the first sample after reset or clear only loads prev (prev_valid=1).
  - On the first change to a legal pattern, enter that phase with run_len=1.
  - Dwell checks are never applied to the partial run seen in SYNC.
- Tracked phases: all checks apply. On a legal change, phase advances.
  - A B_YELLOW→A_GREEN change increments cycle_count; it holds at max.
- FAULT: phase=7; fault and fault_code are frozen; further samples are ignored. cycle_count is held, not cleared.
- fault_clr: in any state, next edge sets phase=SYNC, fault=0, fault_code=0, prev_valid=0. fault_clr takes precedence over a fault detected on the same edge.
- Reset mid-operation: returns immediately to reset values, including cycle_count.

Optional Feature:
- TRAFFIC_MONITOR_DWELL_CHECK_EN.
- Defined: checks 4 and 5 are active as specified.
- Undefined: run_len and the dwell checks are not built. Only encoding, conflict and order are checked, and codes 4/5 never occur.

Test Plan:
- Drive the legal sequence with dwells 6/3/6/3 from reset for 10 full 18-cycle periods → fault=0 throughout; phase steps 1→2→3→4; cycle_count=10.
- In tracked A_GREEN, drive roadA=3'b011 for one sample → after that edge fault=1, fault_code=1, phase=7; later legal samples leave the code unchanged.
- In tracked B_GREEN, drive roadA=GREEN, roadB=GREEN → fault_code=2. Apply fault_clr → phase=0, fault=0 next edge.
- From A_GREEN, change directly to (R,G) → fault_code=3. Also drive (R,R) in SYNC → fault_code=3.
- With the macro defined: A_GREEN held 5 samples then A_YELLOW → fault_code=4. A_YELLOW held 4 samples → fault_code=5 on the 4th sample. With the macro undefined, the same stimulus gives fault=0.
- Assert reset mid-B_YELLOW with cycle_count=3 → outputs are 0 immediately. Raise fault_clr on the same edge as a bad encoding → fault stays 0 and phase=SYNC.
